dram_bus_if: RTL
================

// Module: dram_bus_if
// PURPOSE
//  68040 bus front-end for the DRAM controller. Decodes the DRAM window, latches
//  the address and attributes on TS, and hands one request per beat to the DRAM
//  state machine. Sequences 4-beat line bursts with 68040 wrap order, returns
//  TA (or TEA on timeout) to the CPU, and tracks the open row for page-hit hints.
//  Sits between the CPU bus pins and the DRAM controller state machine.
// PARAMETERS
//  BASE     4'h0  A[31:28] value that selects DRAM
//  ROW_LSB  12    lowest address bit of the DRAM row field
//  ROW_W    12    row field width (page-compare width)
//  TIMEOUT  255   cycles to wait for dram_ack before issuing TEA (max 255, 8-bit count)
// PORTS
//  clk          in   1        system clock (33 MHz); all flops on rising edge
//  nRESET       in   1        asynchronous active-low reset
//  TS_n         in   1        68040 transfer start, active low
//  A            in   32       68040 address
//  SIZ          in   2        68040 size; 2'b11 = line (burst)
//  RW           in   1        1 = read, 0 = write
//  TA_n         out  1        transfer acknowledge to CPU, active low
//  TEA_n        out  1        transfer error acknowledge, active low
//  dram_req     out  1        beat request to the DRAM state machine
//  dram_rw      out  1        latched RW
//  dram_burst   out  1        1 while more beats follow the current one
//  dram_addr    out  30       latched A[31:2]; bits [3:2] advance per beat
//  page_hit     out  1        latched row == open row, and open row valid
//  dram_ack     in   1        one-clk pulse from the DRAM state machine: beat complete
//  refack       in   1        refresh acknowledge; invalidates the open row
// BEHAVIOUR
//  Reset (async): state=IDLE; TA_n=1, TEA_n=1; dram_req=0, dram_burst=0, dram_rw=1;
//   dram_addr=0; open-row valid=0, page_hit=0; beat and wait counters=0.
//  States: IDLE, REQ, DONE.
//  IDLE/DONE: when TS_n=0 and A[31:28]==BASE, latch A[31:2], RW and SIZ, then go to REQ.
//   beats=4 if SIZ==2'b11, else 1. page_hit is computed from the latched row the
//   same cycle and is valid in REQ. TS_n outside the window is ignored (no TA, no TEA).
//  REQ: dram_req=1 and held high; wait counter increments each cycle.
//   On dram_ack:
//    - TA_n=0 on the next cycle, for exactly 1 cycle.
//    - dram_addr[3:2] += 1, modulo 4 (wrap order, e.g. 2,3,0,1); upper bits never change.
//    - beats -= 1 and the wait counter clears.
//    - If that was the last beat: go to DONE, drop dram_req and dram_burst.
//    - Otherwise stay in REQ.
//   dram_burst = (beats remaining > 1).
//  Timeout: wait counter == TIMEOUT without dram_ack -> TEA_n=0 for 1 cycle,
//   dram_req=0, go to IDLE. The remaining beats are abandoned.
//  DONE: lasts 1 cycle (the TA_n cycle of the final beat). Open row <= latched row,
//   valid <= 1. Then go to IDLE, unless a new TS is accepted in DONE.
//  Open row is also loaded on the first dram_ack of every access.
//  refack=1 clears valid; if refack coincides with a row load, refack wins (valid=0).
//  TA_n and TEA_n are never low in the same cycle.
//  dram_ack in IDLE is ignored.
//  Reset mid-burst: all outputs return to reset values at once; no TA is issued
//   for the aborted beats.
//  Latency: TS sampled at edge N -> dram_req high after edge N -> TA_n low one
//   cycle after the edge that samples dram_ack.
// TESTING
//  1 Single read: A=32'h0000_1004, SIZ=2'b10, ack 3 cycles later -> one TA_n pulse,
//    dram_addr=30'h401, dram_burst=0.
//  2 Line write: A=32'h0000_2008, SIZ=2'b11, 4 acks -> dram_addr[3:2]=2,3,0,1;
//    4 TA_n pulses; dram_burst low on the 4th beat.
//  3 Out of window: A=32'h1000_0000 with TS_n=0 -> dram_req stays 0, no TA_n, no TEA_n.
//  4 Timeout: request with no dram_ack -> TEA_n low exactly at wait=255, state IDLE,
//    no TA_n.
//  5 Page: access row 0x001, then another access to row 0x001 -> page_hit=1; refack
//    pulse, then a third access to row 0x001 -> page_hit=0; refack coincident with
//    an ack -> page_hit=0 on the next access.
//  6 Reset after beat 2 of a burst -> dram_req=0, TA_n=1, page_hit=0 immediately;
//    the next TS starts cleanly.

Source files
------------

// File: rtl/dram_bus_if_if.sv
// rtl/dram_bus_if_if.sv - 68040 bus pins and DRAM state machine hand-off signals
interface dram_bus_if_if;
  logic        TS_n;
  logic [31:0] A;
  logic [1:0]  SIZ;
  logic        RW;
  logic        TA_n;
  logic        TEA_n;
  logic        dram_req;
  logic        dram_rw;
  logic        dram_burst;
  logic [29:0] dram_addr;
  logic        page_hit;
  logic        dram_ack;
  logic        refack;

  modport slave (
    input  TS_n, A, SIZ, RW, dram_ack, refack,
    output TA_n, TEA_n, dram_req, dram_rw, dram_burst, dram_addr, page_hit
  );

  modport master (
    output TS_n, A, SIZ, RW, dram_ack, refack,
    input  TA_n, TEA_n, dram_req, dram_rw, dram_burst, dram_addr, page_hit
  );
endinterface

// File: rtl/dram_bus_if.sv
// rtl/dram_bus_if.sv - 68040 front-end: window decode, line-burst sequencing, TA/TEA, open-row tracking
module dram_bus_if #(
  parameter logic [3:0] BASE    = 4'h0,
  parameter int         ROW_LSB = 12,
  parameter int         ROW_W   = 12,
  parameter int         TIMEOUT = 255
) (
  input logic          clk,
  input logic          nRESET,
  dram_bus_if_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_t           state_q;
  logic [29:0]      addr_q;
  logic             rw_q;
  logic             req_q;
  logic             burst_q;
  logic             ta_n_q;
  logic             tea_n_q;
  logic             hit_q;
  logic [2:0]       beats_q;
  logic [7:0]       wait_q;
  logic [ROW_W-1:0] open_row_q;
  logic             open_vld_q;

  logic             ts_sel_d;
  logic             line_d;
  logic [ROW_W-1:0] new_row_d;
  logic [ROW_W-1:0] cur_row_d;
  logic             unused_a;

  assign ts_sel_d  = !bus.TS_n && (bus.A[31:28] == BASE);
  assign line_d    = (bus.SIZ == 2'b11);
  assign new_row_d = bus.A[ROW_LSB +: ROW_W];
  assign cur_row_d = addr_q[ROW_LSB-2 +: ROW_W];
  assign unused_a  = ^bus.A[1:0];

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rw_q       <= 1'b1;
      req_q      <= 1'b0;
      burst_q    <= 1'b0;
      ta_n_q     <= 1'b1;
      tea_n_q    <= 1'b1;
      hit_q      <= 1'b0;
      beats_q    <= 3'd0;
      wait_q     <= 8'd0;
      open_row_q <= '0;
      open_vld_q <= 1'b0;
    end else begin
      ta_n_q  <= 1'b1;
      tea_n_q <= 1'b1;
      case (state_q)
        REQ: begin
          if (bus.dram_ack) begin
            // The open row is loaded with every beat ack, so DONE needs no
            // reload and a refack landing on the final ack stays in effect.
            ta_n_q         <= 1'b0;
            addr_q[1:0]    <= addr_q[1:0] + 2'd1;
            beats_q        <= beats_q - 3'd1;
            wait_q         <= 8'd0;
            open_row_q     <= cur_row_d;
            open_vld_q     <= 1'b1;
            if (beats_q == 3'd1) begin
              state_q <= DONE;
              req_q   <= 1'b0;
              burst_q <= 1'b0;
            end else begin
              burst_q <= (beats_q > 3'd2);
            end
          end else if (wait_q == TO_CNT) begin
            tea_n_q <= 1'b0;
            req_q   <= 1'b0;
            burst_q <= 1'b0;
            beats_q <= 3'd0;
            wait_q  <= 8'd0;
            state_q <= IDLE;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        default: begin
          if (ts_sel_d) begin
            state_q <= REQ;
            addr_q  <= bus.A[31:2];
            rw_q    <= bus.RW;
            beats_q <= line_d ? 3'd4 : 3'd1;
            burst_q <= line_d;
            req_q   <= 1'b1;
            wait_q  <= 8'd0;
            hit_q   <= open_vld_q && !bus.refack && (open_row_q == new_row_d);
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
      if (bus.refack) begin
        open_vld_q <= 1'b0;
      end
    end
  end

  assign bus.TA_n       = ta_n_q;
  assign bus.TEA_n      = tea_n_q;
  assign bus.dram_req   = req_q;
  assign bus.dram_rw    = rw_q;
  assign bus.dram_burst = burst_q;
  assign bus.dram_addr  = addr_q;
  assign bus.page_hit   = hit_q;

endmodule
